// File: rtl/operand_loader.sv
// operand_loader: collects NUM_WORDS operand words from a valid/ready stream on a load request
// Ports: clk rising-edge clock; reset async active-low;
//        loaddata load request; din/din_valid/din_ready operand word stream;
//        clear releases held operands and restarts loading;
//        inputdata_ready all words captured and held; operands word k at [k*DATA_WIDTH +: DATA_WIDTH];
//        word_count words captured in the current load;
//        overrun sticky dropped-word flag, present only with OPERAND_LOADER_OVERRUN_EN defined.
module operand_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_WORDS  = 2,
    parameter int CNT_W      = $clog2(NUM_WORDS + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            loaddata,
    input  logic [DATA_WIDTH-1:0]           din,
    input  logic                            din_valid,
    output logic                            din_ready,
    input  logic                            clear,
    output logic                            inputdata_ready,
    output logic [NUM_WORDS*DATA_WIDTH-1:0] operands,
    output logic [CNT_W-1:0]                word_count
`ifdef OPERAND_LOADER_OVERRUN_EN
    ,
    output logic                            overrun
`endif
);
    localparam int IDX_W = $clog2(NUM_WORDS);
    typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;
    state_t state;
    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] words;
    logic [IDX_W-1:0] idx;
    assign idx       = word_count[IDX_W-1:0];
    assign operands  = words;
    // clear beats an accept in the same cycle
    assign din_ready = state == LOAD && loaddata && !clear;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            inputdata_ready <= 1'b0;
            words           <= '0;
            word_count      <= '0;
        end else begin
            case (state)
                IDLE: if (loaddata) begin
                    state      <= LOAD;
                    word_count <= '0;
                end
                LOAD: if (clear) word_count <= '0;
                else if (din_valid && din_ready) begin
                    words[idx] <= din;
                    word_count <= word_count + CNT_W'(1);
                    if (word_count == CNT_W'(NUM_WORDS - 1)) begin
                        state           <= READY;
                        inputdata_ready <= 1'b1;
                    end
                end
                READY: if (clear) begin
                    state           <= IDLE;
                    inputdata_ready <= 1'b0;
                    word_count      <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef OPERAND_LOADER_OVERRUN_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) overrun <= 1'b0;
        else if (clear) overrun <= 1'b0;
        else if (state == READY && din_valid) overrun <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: randomized and directed checks of operand_loader against a behavioural model
module tb_operand_loader;
    localparam int W = 8;
    localparam int N = 2;
    localparam int CW = $clog2(N + 1);
    logic clk = 1'b0;
    logic reset, loaddata, din_valid, clear;
    logic [W-1:0] din;
    logic din_ready, inputdata_ready;
    logic [N*W-1:0] operands;
    logic [CW-1:0] word_count;
`ifdef OPERAND_LOADER_OVERRUN_EN
    logic overrun;
`endif
    int n_chk = 0;
    int n_fail = 0;
    bit m_armed, m_rdy, m_ovr, exp_dr, obs_dr;
    int m_cnt;
    logic [W-1:0] m_w [N];

    operand_loader #(.DATA_WIDTH(W), .NUM_WORDS(N)) dut (
        .clk(clk), .reset(reset), .loaddata(loaddata), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .clear(clear), .inputdata_ready(inputdata_ready),
        .operands(operands), .word_count(word_count)
`ifdef OPERAND_LOADER_OVERRUN_EN
        , .overrun(overrun)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [N*W-1:0] exp_ops();
        logic [N*W-1:0] r = '0;
        for (int k = 0; k < N; k++) r[k*W +: W] = m_w[k];
        return r;
    endfunction

    task automatic mreset();
        m_armed = 0; m_rdy = 0; m_ovr = 0; m_cnt = 0;
        for (int k = 0; k < N; k++) m_w[k] = '0;
    endtask

    // drive one cycle of inputs, sample din_ready, advance the model across the edge
    task automatic tick(input bit ld, input bit v, input logic [W-1:0] d, input bit clr);
        loaddata = ld; din_valid = v; din = d; clear = clr;
        exp_dr = m_armed && !m_rdy && ld && !clr;
        #1 obs_dr = din_ready;
        @(posedge clk);
        if (clr) m_ovr = 0;
        else if (m_rdy && v) m_ovr = 1;
        if (m_rdy) begin
            if (clr) begin m_rdy = 0; m_armed = 0; m_cnt = 0; end
        end else if (!m_armed) begin
            if (ld) begin m_armed = 1; m_cnt = 0; end
        end else if (clr) m_cnt = 0;
        else if (ld && v) begin
            m_w[m_cnt] = d;
            m_cnt++;
            m_rdy = (m_cnt == N);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; loaddata = 0; din_valid = 0; din = '0; clear = 0;
        mreset();
        repeat (3) @(negedge clk);
        if (inputdata_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%0b exp=0", inputdata_ready); end
        n_chk++;
        if (word_count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", word_count); end
        n_chk++;
        if (operands !== '0) begin n_fail++; $display("FAIL reset_ops got=%h exp=0", operands); end
        n_chk++;
        if (din_ready !== 1'b0) begin n_fail++; $display("FAIL reset_din_ready got=%0b exp=0", din_ready); end
        n_chk++;
        reset = 1'b1;
    endtask

    task automatic test_basic();
        tick(1, 1, 8'h12, 0);
        if (obs_dr !== 1'b0) begin n_fail++; $display("FAIL basic_idle_dr got=%0b exp=0", obs_dr); end
        n_chk++;
        tick(1, 1, 8'h12, 0);
        if (obs_dr !== 1'b1) begin n_fail++; $display("FAIL basic_dr got=%0b exp=1", obs_dr); end
        n_chk++;
        if (inputdata_ready !== 1'b0 || word_count !== CW'(1)) begin
            n_fail++; $display("FAIL basic_first got ready=%0b cnt=%0d exp ready=0 cnt=1", inputdata_ready, word_count);
        end
        n_chk++;
        tick(1, 1, 8'h34, 0);
        if (operands !== 16'h3412 || word_count !== CW'(2) || inputdata_ready !== 1'b1) begin
            n_fail++; $display("FAIL basic_done got ops=%h cnt=%0d ready=%0b exp ops=3412 cnt=2 ready=1", operands, word_count, inputdata_ready);
        end
        n_chk++;
        tick(1, 1, 8'h56, 0);
        if (obs_dr !== 1'b0 || operands !== 16'h3412) begin
            n_fail++; $display("FAIL basic_hold got dr=%0b ops=%h exp dr=0 ops=3412", obs_dr, operands);
        end
        n_chk++;
        tick(0, 0, 0, 1);
        if (inputdata_ready !== 1'b0 || word_count !== '0) begin
            n_fail++; $display("FAIL basic_clear got ready=%0b cnt=%0d exp 0 0", inputdata_ready, word_count);
        end
        n_chk++;
    endtask

    task automatic test_pause();
        tick(1, 0, 0, 0);
        tick(1, 1, 8'h05, 0);
        repeat (4) begin
            tick(0, 1, 8'hAA, 0);
            if (obs_dr !== 1'b0 || word_count !== CW'(1)) begin
                n_fail++; $display("FAIL pause got dr=%0b cnt=%0d exp dr=0 cnt=1", obs_dr, word_count);
            end
            n_chk++;
        end
        tick(1, 1, 8'h07, 0);
        if (operands !== 16'h0705 || inputdata_ready !== 1'b1) begin
            n_fail++; $display("FAIL pause_done got ops=%h ready=%0b exp ops=0705 ready=1", operands, inputdata_ready);
        end
        n_chk++;
        tick(0, 0, 0, 1);
    endtask

    task automatic test_clear_mid();
        tick(1, 0, 0, 0);
        tick(1, 1, 8'h11, 0);
        tick(1, 1, 8'h22, 1);
        if (obs_dr !== 1'b0 || word_count !== '0) begin
            n_fail++; $display("FAIL clear_mid got dr=%0b cnt=%0d exp dr=0 cnt=0", obs_dr, word_count);
        end
        n_chk++;
        tick(1, 1, 8'h33, 0);
        tick(1, 1, 8'h44, 0);
        if (operands !== 16'h4433 || inputdata_ready !== 1'b1) begin
            n_fail++; $display("FAIL clear_mid_done got ops=%h ready=%0b exp ops=4433 ready=1", operands, inputdata_ready);
        end
        n_chk++;
    endtask

    task automatic test_release();
        repeat (5) begin
            tick(0, 1, 8'hFF, 0);
            if (operands !== 16'h4433 || inputdata_ready !== 1'b1 || word_count !== CW'(2)) begin
                n_fail++; $display("FAIL release_frozen got ops=%h ready=%0b cnt=%0d exp ops=4433 ready=1 cnt=2", operands, inputdata_ready, word_count);
            end
            n_chk++;
        end
        tick(0, 0, 0, 1);
        if (inputdata_ready !== 1'b0) begin n_fail++; $display("FAIL release_clear got=%0b exp=0", inputdata_ready); end
        n_chk++;
        tick(1, 0, 0, 0);
        tick(1, 1, 8'h01, 0);
        tick(1, 1, 8'h02, 0);
        if (operands !== 16'h0201 || inputdata_ready !== 1'b1) begin
            n_fail++; $display("FAIL release_reload got ops=%h ready=%0b exp ops=0201 ready=1", operands, inputdata_ready);
        end
        n_chk++;
    endtask

    task automatic test_overrun();
        tick(0, 1, 8'h99, 0);
`ifdef OPERAND_LOADER_OVERRUN_EN
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set got=%0b exp=1", overrun); end
        n_chk++;
        repeat (2) tick(0, 0, 0, 0);
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky got=%0b exp=1", overrun); end
        n_chk++;
`endif
        if (operands !== 16'h0201 || inputdata_ready !== 1'b1) begin
            n_fail++; $display("FAIL overrun_ops got ops=%h ready=%0b exp ops=0201 ready=1", operands, inputdata_ready);
        end
        n_chk++;
        tick(0, 0, 0, 1);
`ifdef OPERAND_LOADER_OVERRUN_EN
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear got=%0b exp=0", overrun); end
        n_chk++;
`endif
    endtask

    task automatic test_async_reset();
        tick(1, 0, 0, 0);
        tick(1, 1, 8'hAB, 0);
        tick(1, 1, 8'hCD, 0);
        #2 reset = 1'b0;
        #1;
        if (inputdata_ready !== 1'b0 || word_count !== '0 || operands !== '0 || din_ready !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got ready=%0b cnt=%0d ops=%h dr=%0b exp all 0", inputdata_ready, word_count, operands, din_ready);
        end
        n_chk++;
        mreset();
        @(negedge clk);
        reset = 1'b1;
        tick(1, 0, 0, 0);
        tick(1, 1, 8'hE1, 0);
        if (word_count !== CW'(1) || operands !== 16'h00E1) begin
            n_fail++; $display("FAIL async_restart got cnt=%0d ops=%h exp cnt=1 ops=00e1", word_count, operands);
        end
        n_chk++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, W'($urandom), $urandom_range(0, 7) == 0);
            if (obs_dr !== exp_dr) begin n_fail++; $display("FAIL rand_dr[%0d] got=%0b exp=%0b", i, obs_dr, exp_dr); end
            n_chk++;
            if (inputdata_ready !== m_rdy) begin n_fail++; $display("FAIL rand_ready[%0d] got=%0b exp=%0b", i, inputdata_ready, m_rdy); end
            n_chk++;
            if (word_count !== CW'(m_cnt)) begin n_fail++; $display("FAIL rand_cnt[%0d] got=%0d exp=%0d", i, word_count, m_cnt); end
            n_chk++;
            if (operands !== exp_ops()) begin n_fail++; $display("FAIL rand_ops[%0d] got=%h exp=%h", i, operands, exp_ops()); end
            n_chk++;
`ifdef OPERAND_LOADER_OVERRUN_EN
            if (overrun !== m_ovr) begin n_fail++; $display("FAIL rand_overrun[%0d] got=%0b exp=%0b", i, overrun, m_ovr); end
            n_chk++;
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pause();
        test_clear_mid();
        test_release();
        test_overrun();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
